// File: rtl/sdram_defs.sv
// Shared SDRAM protocol constants: command encodings, error codes, CAS latency limits.
package sdram_defs;

    // {RAS_N, CAS_N, WE_N} with CS_N low
    typedef enum logic [2:0] {
        CMD_LOAD_MODE  = 3'b000,
        CMD_REFRESH    = 3'b001,
        CMD_PRECHARGE  = 3'b010,
        CMD_ACTIVE     = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_READ       = 3'b101,
        CMD_BURST_TERM = 3'b110,
        CMD_NOP        = 3'b111
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_CLOSED_BANK = 3'd1,
        ERR_ACT_OPEN    = 3'd2,
        ERR_REF_OPEN    = 3'd3,
        ERR_LMR_OPEN    = 3'd4,
        ERR_BAD_CL      = 3'd5,
        ERR_CONTENTION  = 3'd6
    } sdram_err_e;

    localparam logic [2:0] CL_MIN = 3'd2;
    localparam logic [2:0] CL_MAX = 3'd3;
    localparam int         A10    = 10;

    function automatic logic cl_valid(input logic [2:0] v);
        return (v >= CL_MIN) && (v <= CL_MAX);
    endfunction

endpackage

// File: rtl/sdram_byte_ram.sv
// Word array with independent byte write enables and a registered read port.
module sdram_byte_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    we,
    input  logic [15:0]   wdata,
    input  logic          re,
    output logic [15:0]   rdata
);

    logic [7:0] mem_lo [0:(1<<AW)-1];
    logic [7:0] mem_hi [0:(1<<AW)-1];

    // Byte-lane writes and synchronous read; kept in one process so it maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (we[0]) mem_lo[addr] <= wdata[7:0];
        if (we[1]) mem_hi[addr] <= wdata[15:8];
        if (re)    rdata <= {mem_hi[addr], mem_lo[addr]};
    end

endmodule

// File: rtl/sdram_chip_model.sv
// Behavioural SDRAM chip: command decode, per-bank row state, CL-timed read return, protocol checker.
module sdram_chip_model
    import sdram_defs::*;
#(
    parameter int CAS_DEFAULT = 2,
    parameter int ROW_KEEP    = 2
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] DRAM_DQ,
    input  logic [11:0] DRAM_ADDR,
    input  logic        DRAM_LDQM,
    input  logic        DRAM_UDQM,
    input  logic        DRAM_WE_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_BA_0,
    input  logic        DRAM_BA_1,
    output logic        proto_err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_count,
    output logic [15:0] access_count
);

    localparam int AW = 10 + ROW_KEEP;

    sdram_cmd_e        cmd;
    sdram_err_e        err_now;
    logic [1:0]        ba;
    logic [1:0]        dqm;
    logic              hit, any_open, pending;
    logic              rd_ok, wr_ok, ins_cl2, ins_cl3;
    logic [AW-1:0]     word_addr;
    logic [3:0]        bank_open;
    logic [3:0][11:0]  bank_row;
    logic [2:0]        cl;
    logic [15:0]       rdata;

    // Read return pipe: vld_pipe[0] is the CL=3 entry point, CL=2 reads enter at [1], [3] drives the bus.
    logic [3:0]        vld_pipe;
    logic [3:0][1:0]   mask_pipe;
    logic [3:1][15:0]  data_pipe;
    logic              direct;

    // Decode the sampled command and classify any protocol violation it carries.
    always_comb begin
        cmd       = DRAM_CS_N ? CMD_NOP : sdram_cmd_e'({DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N});
        ba        = {DRAM_BA_1, DRAM_BA_0};
        dqm       = {DRAM_UDQM, DRAM_LDQM};
        hit       = bank_open[ba];
        any_open  = |bank_open;
        pending   = |vld_pipe;
        word_addr = {ba, bank_row[ba][ROW_KEEP-1:0], DRAM_ADDR[7:0]};
        rd_ok     = !reset && (cmd == CMD_READ)  && hit;
        wr_ok     = !reset && (cmd == CMD_WRITE) && hit;
        ins_cl3   = rd_ok && (cl == CL_MAX);
        ins_cl2   = rd_ok && (cl != CL_MAX);
        err_now   = ERR_NONE;
        case (cmd)
            CMD_READ:      if (!hit) err_now = ERR_CLOSED_BANK;
            CMD_WRITE:     if (!hit) err_now = ERR_CLOSED_BANK;
                           else if (pending) err_now = ERR_CONTENTION;
            CMD_ACTIVE:    if (hit) err_now = ERR_ACT_OPEN;
            CMD_REFRESH:   if (any_open) err_now = ERR_REF_OPEN;
            CMD_LOAD_MODE: if (any_open) err_now = ERR_LMR_OPEN;
                           else if (!cl_valid(DRAM_ADDR[6:4])) err_now = ERR_BAD_CL;
            default: ;
        endcase
    end

    // Bank state, mode register, counters and first-error latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open     <= '0;
            cl            <= 3'(CAS_DEFAULT);
            proto_err     <= 1'b0;
            err_code      <= 3'd0;
            refresh_count <= '0;
            access_count  <= '0;
        end else begin
            case (cmd)
                CMD_ACTIVE: if (!hit) begin
                    bank_open[ba] <= 1'b1;
                    bank_row[ba]  <= DRAM_ADDR;
                end
                CMD_PRECHARGE: if (DRAM_ADDR[A10]) bank_open <= '0;
                               else bank_open[ba] <= 1'b0;
                CMD_READ, CMD_WRITE: if (hit) begin
                    access_count <= access_count + 16'd1;
                    if (DRAM_ADDR[A10]) bank_open[ba] <= 1'b0;
                end
                CMD_REFRESH: refresh_count <= refresh_count + 16'd1;
                CMD_LOAD_MODE: if (!any_open && cl_valid(DRAM_ADDR[6:4])) cl <= DRAM_ADDR[6:4];
                default: ;
            endcase
            if (err_now != ERR_NONE && !proto_err) begin
                proto_err <= 1'b1;
                err_code  <= err_now;
            end
        end
    end

    // Valid bits of the return pipe; reset and burst terminate drop everything in flight.
    always_ff @(posedge clk) begin
        if (reset || cmd == CMD_BURST_TERM) begin
            vld_pipe <= '0;
            direct   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[2], vld_pipe[1], vld_pipe[0] | ins_cl2, ins_cl3};
            direct   <= ins_cl2;
        end
    end

    // Lane masks and data follow the valid bits; a CL=2 read picks its RAM word straight into stage 2.
    always_ff @(posedge clk) begin
        mask_pipe[0] <= dqm;
        mask_pipe[1] <= ins_cl2 ? dqm : mask_pipe[0];
        mask_pipe[2] <= mask_pipe[1];
        mask_pipe[3] <= mask_pipe[2];
        data_pipe[1] <= rdata;
        data_pipe[2] <= direct ? rdata : data_pipe[1];
        data_pipe[3] <= data_pipe[2];
    end

    assign DRAM_DQ[7:0]  = (vld_pipe[3] && !mask_pipe[3][0]) ? data_pipe[3][7:0]  : 8'hzz;
    assign DRAM_DQ[15:8] = (vld_pipe[3] && !mask_pipe[3][1]) ? data_pipe[3][15:8] : 8'hzz;

    sdram_byte_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .addr  (word_addr),
        .we    ({wr_ok & ~DRAM_UDQM, wr_ok & ~DRAM_LDQM}),
        .wdata (DRAM_DQ),
        .re    (rd_ok),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sdram_chip_model.sv
// Scoreboard bench for sdram_chip_model: a protocol model predicts read data slots and status.
module tb_sdram_chip_model;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    wire  [15:0] DRAM_DQ;
    logic [15:0] dq_drv = '0;
    logic        dq_oe = 1'b0;
    logic [11:0] addr = '0;
    logic        ldqm = 1'b0, udqm = 1'b0;
    logic        we_n = 1'b1, cas_n = 1'b1, ras_n = 1'b1, cs_n = 1'b1;
    logic        ba0 = 1'b0, ba1 = 1'b0;
    logic        proto_err;
    logic [2:0]  err_code;
    logic [15:0] refresh_count, access_count;

    assign DRAM_DQ = dq_oe ? dq_drv : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_chip_model dut (
        .clk(clk), .reset(reset), .DRAM_DQ(DRAM_DQ), .DRAM_ADDR(addr),
        .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm), .DRAM_WE_N(we_n), .DRAM_CAS_N(cas_n),
        .DRAM_RAS_N(ras_n), .DRAM_CS_N(cs_n), .DRAM_BA_0(ba0), .DRAM_BA_1(ba1),
        .proto_err(proto_err), .err_code(err_code),
        .refresh_count(refresh_count), .access_count(access_count)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0;

    typedef struct { int due; logic [15:0] val; } exp_t;
    exp_t sb[$];

    // bench-side protocol model
    logic [15:0] mem_m [int];
    bit   [3:0]  open_m;
    logic [11:0] row_m [4];
    int          cl_m = 2;
    logic [2:0]  err_m = 0;
    int          ref_m = 0, acc_m = 0;
    logic [15:0] obs;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle either a scheduled read word or a floating bus; floated bits are seen as 0.
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) obs[i] = (DRAM_DQ[i] === 1'b1);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("rd_data", obs, sb[0].val);
            void'(sb.pop_front());
        end else if (!dq_oe && !reset) begin
            chk("dq_float", obs, 16'h0000);
        end
    end

    function automatic bit pending();
        foreach (sb[i]) if (sb[i].due >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic flush_from(input int lim);
        exp_t keep[$];
        foreach (sb[i]) if (sb[i].due < lim) keep.push_back(sb[i]);
        sb = keep;
    endtask

    task automatic seterr(input logic [2:0] c);
        if (err_m == 0) err_m = c;
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] a,
                         input logic lm, input logic um, input logic [15:0] d, input bit drv);
        {ras_n, cas_n, we_n} = c;
        cs_n = 1'b0; {ba1, ba0} = ba; addr = a;
        ldqm = lm; udqm = um; dq_drv = d; dq_oe = drv;
        @(posedge clk); #1;
        cs_n = 1'b1; dq_oe = 1'b0; ldqm = 1'b0; udqm = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) issue(3'b111, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic act(input logic [1:0] ba, input logic [11:0] row);
        if (open_m[ba]) seterr(3'd2);
        else begin open_m[ba] = 1'b1; row_m[ba] = row; end
        issue(3'b011, ba, row, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic pre(input logic [1:0] ba, input bit all);
        if (all) open_m = '0; else open_m[ba] = 1'b0;
        issue(3'b010, ba, all ? 12'h400 : 12'h000, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [7:0] col, input logic [15:0] d,
                      input logic lm = 1'b0, input logic um = 1'b0, input bit ap = 1'b0);
        int idx;
        logic [15:0] old;
        if (!open_m[ba]) seterr(3'd1);
        else begin
            if (pending()) seterr(3'd6);
            idx = int'({ba, row_m[ba][1:0], col});
            old = mem_m.exists(idx) ? mem_m[idx] : 16'h0;
            mem_m[idx] = {um ? old[15:8] : d[15:8], lm ? old[7:0] : d[7:0]};
            acc_m++;
            if (ap) open_m[ba] = 1'b0;
        end
        issue(3'b100, ba, {1'b0, ap, 2'b00, col}, lm, um, d, 1'b1);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [7:0] col,
                      input logic lm = 1'b0, input logic um = 1'b0, input bit ap = 1'b0);
        int idx;
        logic [15:0] m;
        exp_t e;
        if (!open_m[ba]) seterr(3'd1);
        else begin
            idx = int'({ba, row_m[ba][1:0], col});
            m = mem_m.exists(idx) ? mem_m[idx] : 16'h0;
            e.due = cyc + 1 + cl_m;
            e.val = {um ? 8'h00 : m[15:8], lm ? 8'h00 : m[7:0]};
            sb.push_back(e);
            acc_m++;
            if (ap) open_m[ba] = 1'b0;
        end
        issue(3'b101, ba, {1'b0, ap, 2'b00, col}, lm, um, 16'h0, 1'b0);
    endtask

    task automatic refr();
        if (open_m != 0) seterr(3'd3);
        ref_m++;
        issue(3'b001, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic lmr(input logic [2:0] v);
        if (open_m != 0) seterr(3'd4);
        else if (v == 3'd2 || v == 3'd3) cl_m = int'(v);
        else seterr(3'd5);
        issue(3'b000, 2'd0, {5'b0, v, 4'b0}, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic bst();
        issue(3'b110, 2'd0, 12'h000, 1'b0, 1'b0, 16'h0, 1'b0);
        flush_from(cyc);
    endtask

    task automatic rst();
        reset = 1'b1; cs_n = 1'b1; dq_oe = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        flush_from(cyc);
        open_m = '0; cl_m = 2; err_m = 0; ref_m = 0; acc_m = 0;
    endtask

    task automatic status(input string t);
        chk({t, "/err_code"}, 16'(err_code), 16'(err_m));
        chk({t, "/proto_err"}, 16'(proto_err), 16'(err_m != 0));
        chk({t, "/refresh_count"}, refresh_count, 16'(ref_m));
        chk({t, "/access_count"}, access_count, 16'(acc_m));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        open_m = '0;
        status("reset");

        // write, read back at CL=2, byte-masked write and masked read
        act(2'd0, 12'h001);
        wr(2'd0, 8'h12, 16'hBEEF);
        nop(1);
        rd(2'd0, 8'h12);
        nop(4);
        wr(2'd0, 8'h12, 16'h1234, 1'b0, 1'b1);
        rd(2'd0, 8'h12);
        nop(4);
        rd(2'd0, 8'h12, 1'b1, 1'b0);
        nop(4);
        status("masked");

        // switch to CL=3
        pre(2'd0, 1'b1);
        lmr(3'd3);
        act(2'd0, 12'h001);
        rd(2'd0, 8'h12);
        nop(5);

        // closed-bank read, then ACTIVE to an open bank must not overwrite the first code
        rd(2'd2, 8'h00);
        nop(4);
        status("closed_rd");
        act(2'd0, 12'h001);
        status("first_err_kept");

        // auto-precharge read followed by a read to the now-closed bank; back-to-back burst of four
        rst();
        act(2'd1, 12'h002);
        for (int i = 0; i < 4; i++) wr(2'd1, 8'(i), {8'hA0 + 8'(i), 8'h51 + 8'(i)});
        nop(1);
        rd(2'd1, 8'h00, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 8'h01);
        nop(4);
        status("autopre");
        act(2'd1, 12'h002);
        for (int i = 0; i < 4; i++) rd(2'd1, 8'(i));
        nop(5);

        // contention: write while a read is still in flight
        rst();
        act(2'd0, 12'h001);
        rd(2'd0, 8'h12);
        wr(2'd0, 8'h12, 16'h5678);
        nop(4);
        status("contention");
        rd(2'd0, 8'h12);
        nop(4);

        // unsupported CAS latency leaves CL at 2
        rst();
        lmr(3'd5);
        status("bad_cl");
        act(2'd0, 12'h001);
        rd(2'd0, 8'h12);
        nop(4);

        // controller-style init then eight refreshes
        rst();
        nop(2);
        pre(2'd0, 1'b1);
        lmr(3'd3);
        for (int i = 0; i < 8; i++) refr();
        nop(1);
        status("refresh");

        // burst terminate kills a pending read; reset right after a read kills it too
        act(2'd3, 12'h005);
        wr(2'd3, 8'h07, 16'hA55A);
        nop(1);
        rd(2'd3, 8'h07);
        bst();
        nop(4);
        rd(2'd3, 8'h07);
        rst();
        nop(4);
        status("reset_mid_read");
        act(2'd3, 12'h005);
        rd(2'd3, 8'h07);
        rd(2'd0, 8'h00);
        nop(5);
        status("after_reset");

        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

endmodule
